// File: rtl/velocity_ctrl_pkg.sv
// Shared types and constants for the per-cell velocity memory sweep controller.
package velocity_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_CNT,
        ST_WAIT_CNT,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int VEL_COMP_WIDTH = 32;
    localparam int COUNT_ADDR     = 0;

endpackage

// File: rtl/velocity_mem_sweep_ctrl_rd_latency_pipe.sv
// Tracks in-flight RAM reads so returning data can be tagged with its address.
module rd_latency_pipe #(
    parameter int ADDR_WIDTH = 8,
    parameter int RD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_is_cnt,
    output logic                  o_valid,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_is_cnt,
    output logic                  o_busy
);

    logic [RD_LATENCY-1:0] r_valid;
    logic [RD_LATENCY-1:0] r_is_cnt;
    logic [ADDR_WIDTH-1:0] r_addr [RD_LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid  <= '0;
            r_is_cnt <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_addr[i] <= '0;
            end
        end else begin
            r_valid[0]  <= i_valid;
            r_is_cnt[0] <= i_is_cnt;
            r_addr[0]   <= i_addr;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_valid[i]  <= r_valid[i-1];
                r_is_cnt[i] <= r_is_cnt[i-1];
                r_addr[i]   <= r_addr[i-1];
            end
        end
    end

    assign o_valid  = r_valid[RD_LATENCY-1];
    assign o_is_cnt = r_is_cnt[RD_LATENCY-1];
    assign o_addr   = r_addr[RD_LATENCY-1];
    assign o_busy   = |r_valid;

endmodule

// File: rtl/velocity_mem_sweep_ctrl.sv
// Per-cell velocity RAM sequencer: count read, ascending stream sweep,
// and write-back arbitration on the single RAM port.
module velocity_mem_sweep_ctrl
    import velocity_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = 3 * VEL_COMP_WIDTH,
    parameter int PARTICLE_NUM = 220,
    parameter int ADDR_WIDTH   = 8,
    parameter int RD_LATENCY   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] particle_count,
    input  logic                  wb_valid,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  wb_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rden,
    output logic                  mem_wren,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  out_valid,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_vel
);

    localparam logic [ADDR_WIDTH-1:0] LP_MAX_ADDR = ADDR_WIDTH'(PARTICLE_NUM - 1);
    localparam logic [ADDR_WIDTH-1:0] LP_CNT_ADDR = ADDR_WIDTH'(COUNT_ADDR);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH-1:0] w_rd_ptr_nxt;
    logic [ADDR_WIDTH-1:0] r_count;
    logic [ADDR_WIDTH-1:0] w_count_nxt;
    logic                  r_wb_err;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic                  r_mem_rden;
    logic                  r_mem_wren;
    logic [DATA_WIDTH-1:0] r_mem_data;
    logic                  r_rd_is_cnt;

    logic                  w_wb_legal;
    logic                  w_wb_illegal;
    logic                  w_port_free;
    logic                  w_rd_issue;
    logic                  w_rd_is_cnt;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic [ADDR_WIDTH-1:0] w_cnt_raw;
    logic [ADDR_WIDTH-1:0] w_cnt_clamp;
    logic                  w_pipe_valid;
    logic [ADDR_WIDTH-1:0] w_pipe_addr;
    logic                  w_pipe_is_cnt;
    logic                  w_pipe_busy;

    assign w_wb_legal   = wb_valid && (wb_addr != '0) && (wb_addr <= LP_MAX_ADDR);
    assign w_wb_illegal = wb_valid && !w_wb_legal;
    assign w_port_free  = !w_wb_legal;

    assign w_cnt_raw   = mem_q[ADDR_WIDTH-1:0];
    assign w_cnt_clamp = (w_cnt_raw > LP_MAX_ADDR) ? LP_MAX_ADDR : w_cnt_raw;

    always_comb begin
        w_state_nxt  = r_state;
        w_rd_ptr_nxt = r_rd_ptr;
        w_count_nxt  = r_count;
        w_rd_issue   = 1'b0;
        w_rd_is_cnt  = 1'b0;
        w_rd_addr    = r_rd_ptr;
        unique case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_RD_CNT;
            end
            ST_RD_CNT: begin
                if (w_port_free) begin
                    w_rd_issue  = 1'b1;
                    w_rd_is_cnt = 1'b1;
                    w_rd_addr   = LP_CNT_ADDR;
                    w_state_nxt = ST_WAIT_CNT;
                end
            end
            ST_WAIT_CNT: begin
                if (w_pipe_valid && w_pipe_is_cnt) begin
                    w_count_nxt = w_cnt_clamp;
                    if (w_cnt_clamp == '0) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_rd_ptr_nxt = ADDR_WIDTH'(1);
                        w_state_nxt  = ST_STREAM;
                    end
                end
            end
            ST_STREAM: begin
                if (w_port_free) begin
                    w_rd_issue = 1'b1;
                    if (r_rd_ptr == r_count) begin
                        w_state_nxt = ST_DRAIN;
                    end else begin
                        w_rd_ptr_nxt = r_rd_ptr + ADDR_WIDTH'(1);
                    end
                end
            end
            // The registered request counts as in flight until it enters the pipe.
            ST_DRAIN: begin
                if (!r_mem_rden && !w_pipe_busy) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_wb_err <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            if (w_wb_illegal) r_wb_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_addr  <= '0;
            r_mem_rden  <= 1'b0;
            r_mem_wren  <= 1'b0;
            r_mem_data  <= '0;
            r_rd_is_cnt <= 1'b0;
        end else begin
            r_mem_wren  <= w_wb_legal;
            r_mem_rden  <= w_rd_issue;
            r_rd_is_cnt <= w_rd_is_cnt;
            if (w_wb_legal) begin
                r_mem_addr <= wb_addr;
                r_mem_data <= wb_data;
            end else if (w_rd_issue) begin
                r_mem_addr <= w_rd_addr;
            end
        end
    end

    rd_latency_pipe #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RD_LATENCY (RD_LATENCY)
    ) u_pipe (
        .clk      (clk),
        .rst      (rst),
        .i_valid  (r_mem_rden),
        .i_addr   (r_mem_addr),
        .i_is_cnt (r_rd_is_cnt),
        .o_valid  (w_pipe_valid),
        .o_addr   (w_pipe_addr),
        .o_is_cnt (w_pipe_is_cnt),
        .o_busy   (w_pipe_busy)
    );

    assign busy           = (r_state != ST_IDLE);
    assign done           = (r_state == ST_DONE);
    assign particle_count = r_count;
    assign wb_err         = r_wb_err;
    assign mem_addr       = r_mem_addr;
    assign mem_rden       = r_mem_rden;
    assign mem_wren       = r_mem_wren;
    assign mem_data       = r_mem_data;
    assign out_valid      = w_pipe_valid && !w_pipe_is_cnt;
    assign out_addr       = out_valid ? w_pipe_addr : '0;
    assign out_vel        = out_valid ? mem_q : '0;

endmodule

// File: tb/tb_velocity_mem_sweep_ctrl.sv
// Scoreboard bench: directed sweeps against a 2-cycle-latency RAM model.
module tb_velocity_mem_sweep_ctrl;

    localparam int DW = 96;
    localparam int AW = 8;
    localparam int PN = 220;
    localparam logic [95:0] A5 = {12{8'hA5}};

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic [AW-1:0] particle_count;
    logic          wb_valid;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          wb_err;
    logic [AW-1:0] mem_addr;
    logic          mem_rden;
    logic          mem_wren;
    logic [DW-1:0] mem_data;
    logic [DW-1:0] mem_q;
    logic          out_valid;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_vel;

    velocity_mem_sweep_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .particle_count (particle_count),
        .wb_valid       (wb_valid),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .wb_err         (wb_err),
        .mem_addr       (mem_addr),
        .mem_rden       (mem_rden),
        .mem_wren       (mem_wren),
        .mem_data       (mem_data),
        .mem_q          (mem_q),
        .out_valid      (out_valid),
        .out_addr       (out_addr),
        .out_vel        (out_vel)
    );

    always #5 clk = ~clk;

    function automatic logic [95:0] pat(input int a);
        return {32'hC0DE0000 + 32'(a), 32'h5A000000 + 32'(a) * 32'd7, ~32'(a)};
    endfunction

    logic          ram_init;
    logic          ld_en;
    logic [DW-1:0] ld_data;
    logic [DW-1:0] ram [PN];
    logic [AW-1:0] ram_a;

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < PN; i++) ram[i] <= pat(i);
        end else if (ld_en) begin
            ram[0] <= ld_data;
        end else if (mem_wren && mem_addr < PN) begin
            ram[mem_addr] <= mem_data;
        end
        ram_a <= mem_addr;
        mem_q <= (ram_a < PN) ? ram[ram_a] : '0;
    end

    int            tests = 0;
    int            fails = 0;
    logic [103:0]  exp_q [$];
    logic [95:0]   golden [PN];
    int            beats = 0;
    int            reads = 0;
    int            wrens = 0;
    int            done_cnt = 0;
    int            cyc = 0;
    int            rd_log [$];
    int            beat_cyc [$];
    int            last_beat_addr = 0;
    logic [95:0]   last_wr_data = '0;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (out_valid) begin
                logic [103:0] e;
                beats++;
                beat_cyc.push_back(cyc);
                last_beat_addr = int'(out_addr);
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_beat: addr %0d with empty queue", out_addr);
                end else begin
                    e = exp_q.pop_front();
                    if (out_addr !== e[103:96] || out_vel !== e[95:0]) begin
                        fails++;
                        $display("FAIL beat: got addr %0d vel %h, expected addr %0d vel %h",
                                 out_addr, out_vel, e[103:96], e[95:0]);
                    end
                end
            end
            if (done) done_cnt++;
            if (mem_rden) begin
                reads++;
                rd_log.push_back(int'(mem_addr));
            end
            if (mem_wren) begin
                wrens++;
                last_wr_data = mem_data;
            end
            if (mem_rden && mem_wren) begin
                tests++;
                fails++;
                $display("FAIL rd_wr_collision: rden %b wren %b, expected not both", mem_rden, mem_wren);
            end
        end
    end

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_count(input logic [95:0] w);
        @(posedge clk); #1;
        ld_en = 1'b1;
        ld_data = w;
        @(posedge clk); #1;
        ld_en = 1'b0;
        golden[0] = w;
    endtask

    task automatic push_exp(input int n);
        for (int i = 1; i <= n; i++) exp_q.push_back({8'(i), golden[i]});
    endtask

    task automatic pulse_start;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int base, input string nm);
        int k = 0;
        while (done_cnt == base && k < 2000) begin
            @(posedge clk);
            k++;
        end
        #1;
        check(nm, 128'(done_cnt - base), 128'd1);
        check({nm, "_busy"}, 128'(busy), 128'd0);
    endtask

    task automatic wait_beats(input int target);
        int k = 0;
        while (beats < target && k < 500) begin
            @(posedge clk);
            k++;
        end
        check("beat_wait", 128'(beats >= target), 128'd1);
    endtask

    int r0, b0, d0, w0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        ld_en = 1'b0; ld_data = '0; ram_init = 1'b1;
        for (int i = 0; i < PN; i++) golden[i] = pat(i);
        @(posedge clk); #1;
        ram_init = 1'b0;
        check("rst_busy", 128'(busy), 0);
        check("rst_done", 128'(done), 0);
        check("rst_outv", 128'(out_valid), 0);
        check("rst_mem_ctl", 128'({mem_rden, mem_wren, mem_addr}), 0);
        check("rst_pc_err", 128'({particle_count, wb_err}), 0);
        check("rst_vel", 128'(out_vel), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // count 5, plain sweep
        set_count(96'd5);
        push_exp(5);
        r0 = reads; b0 = beats; d0 = done_cnt;
        pulse_start;
        wait_done(d0, "t1_done");
        check("t1_reads", 128'(reads - r0), 128'd6);
        check("t1_first_rd", 128'(rd_log[r0]), 128'd0);
        check("t1_last_rd", 128'(rd_log[r0+5]), 128'd5);
        check("t1_beats", 128'(beats - b0), 128'd5);
        check("t1_span", 128'(beat_cyc[b0+4] - beat_cyc[b0]), 128'd4);
        check("t1_pc", 128'(particle_count), 128'd5);
        check("t1_q_empty", 128'(exp_q.size()), 128'd0);

        // count 0
        set_count(96'd0);
        r0 = reads; b0 = beats; d0 = done_cnt;
        pulse_start;
        wait_done(d0, "t2_done");
        check("t2_reads", 128'(reads - r0), 128'd1);
        check("t2_beats", 128'(beats - b0), 128'd0);
        check("t2_pc", 128'(particle_count), 128'd0);

        // count 8 with three write-backs to addr 2 mid-stream
        set_count(96'd8);
        push_exp(8);
        r0 = reads; b0 = beats; d0 = done_cnt; w0 = wrens;
        pulse_start;
        wait_beats(b0 + 3);
        #1;
        wb_valid = 1'b1; wb_addr = 8'd2; wb_data = A5;
        repeat (3) @(posedge clk);
        #1;
        wb_valid = 1'b0;
        golden[2] = A5;
        wait_done(d0, "t3_done");
        check("t3_wrens", 128'(wrens - w0), 128'd3);
        check("t3_wr_data", 128'(last_wr_data), 128'(A5));
        check("t3_beats", 128'(beats - b0), 128'd8);
        check("t3_span", 128'(beat_cyc[b0+7] - beat_cyc[b0]), 128'd10);
        check("t3_reads", 128'(reads - r0), 128'd9);
        check("t3_q_empty", 128'(exp_q.size()), 128'd0);
        push_exp(8);
        b0 = beats; d0 = done_cnt;
        pulse_start;
        wait_done(d0, "t3b_done");
        check("t3b_beats", 128'(beats - b0), 128'd8);
        check("t3b_q_empty", 128'(exp_q.size()), 128'd0);

        // count 250 clamps to 219; illegal write-backs
        set_count({64'h1, 32'h000000FA});
        push_exp(PN - 1);
        b0 = beats; d0 = done_cnt;
        pulse_start;
        wait_done(d0, "t4_done");
        check("t4_pc", 128'(particle_count), 128'd219);
        check("t4_beats", 128'(beats - b0), 128'd219);
        check("t4_last_addr", 128'(last_beat_addr), 128'd219);
        check("t4_q_empty", 128'(exp_q.size()), 128'd0);
        check("t4_err_pre", 128'(wb_err), 128'd0);
        w0 = wrens;
        @(posedge clk); #1;
        wb_valid = 1'b1; wb_addr = 8'd0; wb_data = A5;
        @(posedge clk); #1;
        wb_valid = 1'b0;
        repeat (2) @(posedge clk); #1;
        check("t4_err_a0", 128'(wb_err), 128'd1);
        check("t4_wren_a0", 128'(wrens - w0), 128'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t4_err_clr", 128'(wb_err), 128'd0);
        w0 = wrens;
        wb_valid = 1'b1; wb_addr = 8'd230;
        @(posedge clk); #1;
        wb_valid = 1'b0;
        repeat (2) @(posedge clk); #1;
        check("t4_err_a230", 128'(wb_err), 128'd1);
        check("t4_wren_a230", 128'(wrens - w0), 128'd0);

        // reset mid-stream, then a full sweep
        set_count(96'd5);
        push_exp(5);
        b0 = beats; d0 = done_cnt;
        pulse_start;
        wait_beats(b0 + 3);
        #1;
        rst = 1'b1;
        #1;
        check("t5_busy", 128'(busy), 0);
        check("t5_outs", 128'({out_valid, out_addr, done, particle_count, wb_err}), 0);
        check("t5_mem", 128'({mem_rden, mem_wren, mem_addr}), 0);
        check("t5_data", 128'(mem_data), 0);
        check("t5_vel", 128'(out_vel), 0);
        exp_q.delete();
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        check("t5_no_done", 128'(done_cnt - d0), 128'd0);
        push_exp(5);
        r0 = reads; b0 = beats; d0 = done_cnt;
        pulse_start;
        wait_done(d0, "t5_done");
        check("t5_first_rd", 128'(rd_log[r0]), 128'd0);
        check("t5_reads", 128'(reads - r0), 128'd6);
        check("t5_beats", 128'(beats - b0), 128'd5);

        // start repeated while busy
        push_exp(5);
        r0 = reads; b0 = beats; d0 = done_cnt;
        pulse_start;
        @(posedge clk);
        pulse_start;
        pulse_start;
        wait_done(d0, "t6_done");
        repeat (20) @(posedge clk);
        #1;
        check("t6_one_done", 128'(done_cnt - d0), 128'd1);
        check("t6_reads", 128'(reads - r0), 128'd6);
        check("t6_beats", 128'(beats - b0), 128'd5);
        check("t6_q_empty", 128'(exp_q.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/velocity_mem_sweep_ctrl.md
Name: velocity_mem_sweep_ctrl

Overview:
- Sequences one cell's single-port velocity memory (1 port, 96-bit {vz,vy,vx} words; address 0 holds the particle count) for the motion-update pass.
- On start, reads the count word, then streams velocities for addresses 1..count to the motion-update unit.
- Arbitrates the single port between that read sweep and velocity write-backs from the motion-update unit; write-backs always win.
- Sits between the per-cell velocity RAM and the motion-update pipeline, one instance per cell.

Parameters:
- DATA_WIDTH, 96, velocity word width {vz,vy,vx}, 32 bits each.
- PARTICLE_NUM, 220, RAM depth in words, including the count word.
- ADDR_WIDTH, 8, RAM address width.
- RD_LATENCY, 2, cycles from mem_rden/mem_addr to valid mem_q (address register plus output register).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse; begins a sweep when idle.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse when the sweep completes.
- particle_count  out  ADDR_WIDTH  count latched from word 0, after clamping.
- wb_valid  in  1  write-back request; always accepted in the same cycle.
- wb_addr  in  ADDR_WIDTH  write-back particle address.
- wb_data  in  DATA_WIDTH  new velocity.
- wb_err  out  1  sticky; set by an illegal write-back address; cleared only by reset.
- mem_addr  out  ADDR_WIDTH  RAM address.
- mem_rden  out  1  RAM read enable.
- mem_wren  out  1  RAM write enable.
- mem_data  out  DATA_WIDTH  RAM write data.
- mem_q  in  DATA_WIDTH  RAM read data.
- out_valid  out  1  streamed velocity valid.
- out_addr  out  ADDR_WIDTH  particle address of out_vel.
- out_vel  out  DATA_WIDTH  streamed velocity.

Behaviour:
- Reset (async): state=IDLE. All outputs 0: busy, done, out_valid, out_addr, out_vel, mem_*, particle_count, wb_err. Latency pipe cleared.
- Reset mid-sweep abandons the sweep; no done pulse.
- All mem_* outputs are registered, so the RAM sees a request one cycle after the decision.

Port arbitration (every cycle, in priority order):
- Legal write-back: wb_valid and 1 <= wb_addr <= PARTICLE_NUM-1. Drives mem_wren=1, mem_addr=wb_addr, mem_data=wb_data, mem_rden=0. Any read due that cycle stalls one cycle, and the read address is held.
- Illegal write-back (wb_addr 0 or >= PARTICLE_NUM): dropped, wb_err set, and the port is free for a read in the same cycle.
- Otherwise the FSM may issue a read.

FSM:
- IDLE: on start, set busy and go to RD_CNT. start is ignored while busy.
- RD_CNT: issue a read of address 0 when the port is free, then go to WAIT_CNT.
- WAIT_CNT: after RD_LATENCY cycles, latch c = mem_q[ADDR_WIDTH-1:0] and clamp it to PARTICLE_NUM-1.
  - c==0: go to DONE.
  - Otherwise set rd_ptr=1 and go to STREAM.
- STREAM: issue a read of rd_ptr on each free cycle and increment rd_ptr. After issuing rd_ptr==count, go to DRAIN. No wrap-around; rd_ptr never exceeds count.
- DRAIN: wait until the latency pipe is empty, then go to DONE.
- DONE: pulse done for 1 cycle, clear busy, return to IDLE. particle_count holds until the next sweep.

Latency pipe and output:
- Shift register, depth RD_LATENCY, of {valid, addr, is_cnt}.
- out_valid=1 exactly RD_LATENCY cycles after a streaming read was presented on mem_*. out_addr is the pipe address; out_vel=mem_q.
- The count-word read never asserts out_valid.
- Output order is strictly ascending address. No backpressure: the consumer must accept every beat.

Write-back and read interaction:
- Write-backs are legal in any state, including IDLE.
- A write-back to an address already read in this sweep does not re-stream.
- A read and a write are never issued in the same cycle, so read-during-write mode is irrelevant.
- Unclamped throughput: count reads in count + (write-back cycles) cycles.

Decomposition:
- Shared package (velocity_ctrl_pkg): FSM state encoding (IDLE, RD_CNT, WAIT_CNT, STREAM, DRAIN, DONE), VEL_COMP_WIDTH=32, COUNT_ADDR=0.
- One natural sub-module: rd_latency_pipe (parameterised RD_LATENCY-deep {valid, addr, is_cnt} shift register).
- The FSM and arbitration stay in the top.

Test Plan:
- Count word=5, no write-backs, start pulse: reads of addr 0,1..5; out_valid for 5 consecutive cycles with out_addr 1..5 and the matching RAM data; done at sweep end; particle_count=5.
- Count=0: exactly one mem read (addr 0), no out_valid, done pulse, busy low afterwards.
- Count=8 with wb_valid asserted on 3 cycles mid-stream (addr 2, data 96'hA5...): the 3 writes reach the RAM, the stream stalls 3 cycles, out_addr stays 1..8 with no gap or duplicate, and a later read of addr 2 returns 96'hA5....
- Count word=250 with PARTICLE_NUM=220: particle_count=219 and the last out_addr is 219. wb_addr=0 and wb_addr=230 each set wb_err and no mem_wren occurs.
- rst asserted in STREAM after 3 beats: all outputs 0 immediately. A new start after deassertion performs a full sweep from address 0.
- start pulsed again while busy: ignored, with exactly one done pulse per accepted start.
